// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator running off a divided pixel strobe
//   in : clk, reset (async, active-high), en (run enable)
//   out: pix_ce, pix_clk, x, y, hsync, vsync, blank_b, sync_b, line_start, frame_start, frame_cnt
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 11,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 32,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int PIPE_DLY = 0,
   parameter int CW       = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic          pix_ce,
   output logic          pix_clk,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          blank_b,
   output logic          sync_b,
   output logic          line_start,
   output logic          frame_start,
   output logic [15:0]   frame_cnt
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [CW:0] H_ACT  = (CW+1)'(H_ACTIVE);
   localparam logic [CW:0] H_SS   = (CW+1)'(H_ACTIVE + H_FP);
   localparam logic [CW:0] H_SE   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0] H_LAST = (CW+1)'(H_TOTAL - 1);
   localparam logic [CW:0] V_ACT  = (CW+1)'(V_ACTIVE);
   localparam logic [CW:0] V_SS   = (CW+1)'(V_ACTIVE + V_FP);
   localparam logic [CW:0] V_SE   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW:0] V_LAST = (CW+1)'(V_TOTAL - 1);

   if (CLK_DIV < 1) begin : g_chk_div
      $error("CLK_DIV must be at least 1");
   end
   if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_chk_dly
      $error("PIPE_DLY must be within 0..7");
   end
   if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_chk_cw
      $error("CW too narrow for the raster totals");
   end

   logic [DW-1:0] r_div;
   logic          r_pix_clk;
   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic [15:0]   r_frame_cnt;
   logic [DW-1:0] w_div_nx;
   logic          w_tick;
   logic          w_run;
   logic          w_x_wrap;
   logic          w_y_wrap;
   logic [CW:0]   w_xe;
   logic [CW:0]   w_ye;
   logic [2:0]    w_raw;
   logic [2:0]    w_dly;

   assign w_tick   = r_div == DIV_LAST;
   assign w_div_nx = w_tick ? '0 : r_div + 1'b1;
   // decode is forced inactive while idle or in reset so the direct path shows reset values
   assign w_run    = en & ~reset;
   assign w_xe     = {1'b0, r_x};
   assign w_ye     = {1'b0, r_y};
   assign w_x_wrap = w_xe == H_LAST;
   assign w_y_wrap = w_ye == V_LAST;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div     <= '0;
         r_pix_clk <= 1'b0;
      end else begin
         r_div     <= w_div_nx;
         // registered from the next divider value so pix_clk tracks div without lag
         r_pix_clk <= (CLK_DIV > 1) && (w_div_nx >= DIV_HALF);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x         <= '0;
         r_y         <= '0;
         r_frame_cnt <= '0;
      end else if (!en) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_tick) begin
         r_x <= w_x_wrap ? '0 : r_x + 1'b1;
         if (w_x_wrap) begin
            r_y <= w_y_wrap ? '0 : r_y + 1'b1;
            if (w_y_wrap) r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign w_raw = {w_run & (w_xe < H_ACT) & (w_ye < V_ACT),
                   w_run & (w_xe >= H_SS) & (w_xe < H_SE),
                   w_run & (w_ye >= V_SS) & (w_ye < V_SE)};

   if (PIPE_DLY == 0) begin : g_direct
      assign w_dly = w_raw;
   end else begin : g_pipe
      logic [2:0] r_dly [PIPE_DLY];
      always_ff @(posedge clk or posedge reset) begin
         if (reset || !en) begin
            r_dly <= '{default: '0};
         end else if (w_tick) begin
            r_dly[0] <= w_raw;
            for (int i = 1; i < PIPE_DLY; i++) r_dly[i] <= r_dly[i-1];
         end
      end
      assign w_dly = r_dly[PIPE_DLY-1];
   end

   assign pix_ce      = w_tick & ~reset;
   assign pix_clk     = r_pix_clk;
   assign x           = r_x;
   assign y           = r_y;
   assign blank_b     = w_dly[2];
   assign hsync       = w_dly[1] ~^ 1'(H_POL);
   assign vsync       = w_dly[0] ~^ 1'(V_POL);
   assign sync_b      = 1'b0;
   assign line_start  = w_run & w_tick & (r_x == '0);
   assign frame_start = line_start & (r_y == '0);
   assign frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for three vga_timing_gen configurations
module tb_vga_timing_gen;
   localparam int CW = 6;
   localparam int HT = 16;
   localparam int VT = 8;
   localparam int FT = HT * VT;
   localparam int OW = 2 * CW + 23;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b0;
   always #5 clk = ~clk;

   logic          ce [3], pclk [3], hs [3], vs [3], bb [3], sb [3], ls [3], fs [3];
   logic [CW-1:0] xx [3], yy [3];
   logic [15:0]   fc [3];

   vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2),
      .V_BP(1), .H_POL(0), .V_POL(0), .PIPE_DLY(0), .CW(CW)) u0 (
      .clk(clk), .reset(reset), .en(en), .pix_ce(ce[0]), .pix_clk(pclk[0]), .x(xx[0]), .y(yy[0]),
      .hsync(hs[0]), .vsync(vs[0]), .blank_b(bb[0]), .sync_b(sb[0]), .line_start(ls[0]),
      .frame_start(fs[0]), .frame_cnt(fc[0]));
   vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2),
      .V_BP(1), .H_POL(1), .V_POL(0), .PIPE_DLY(2), .CW(CW)) u1 (
      .clk(clk), .reset(reset), .en(en), .pix_ce(ce[1]), .pix_clk(pclk[1]), .x(xx[1]), .y(yy[1]),
      .hsync(hs[1]), .vsync(vs[1]), .blank_b(bb[1]), .sync_b(sb[1]), .line_start(ls[1]),
      .frame_start(fs[1]), .frame_cnt(fc[1]));
   vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2),
      .V_BP(1), .H_POL(0), .V_POL(0), .PIPE_DLY(0), .CW(CW)) u2 (
      .clk(clk), .reset(reset), .en(en), .pix_ce(ce[2]), .pix_clk(pclk[2]), .x(xx[2]), .y(yy[2]),
      .hsync(hs[2]), .vsync(vs[2]), .blank_b(bb[2]), .sync_b(sb[2]), .line_start(ls[2]),
      .frame_start(fs[2]), .frame_cnt(fc[2]));

   int vectors = 0;
   int miscompares = 0;

   // reference model: position is simply the count of enabled pixel ticks since (0,0)
   int          div [3];
   int          n [3];
   logic [15:0] mfc [3];
   logic [2:0]  dl [3][$];
   logic [OW-1:0] sq [3][$];

   bit track = 1'b0;
   int tk0 = 0, last_fs = -1, fs_cnt = 0, ls_cnt = 0;

   function automatic int cdiv(input int i);
      return (i == 2) ? 1 : 2;
   endfunction
   function automatic int pdly(input int i);
      return (i == 1) ? 2 : 0;
   endfunction
   function automatic logic hpol(input int i);
      return i == 1;
   endfunction

   function automatic logic [2:0] raw(input int p, input logic e);
      int px = p % HT;
      int py = p / HT;
      return {e && px < 8 && py < 4, e && px >= 10 && px < 13, e && py >= 5 && py < 7};
   endfunction

   function automatic logic [OW-1:0] dv(input int i);
      return {pclk[i], xx[i], yy[i], hs[i], vs[i], bb[i], sb[i], ls[i], fs[i], fc[i]};
   endfunction

   function automatic logic [OW-1:0] rst_vec(input int i);
      return {1'b0, CW'(0), CW'(0), ~hpol(i), 1'b1, 4'b0000, 16'h0000};
   endfunction

   function automatic logic [OW-1:0] exp_vec(input int i);
      int px = n[i] % HT;
      int py = n[i] / HT;
      logic c = div[i] == cdiv(i) - 1;
      logic pc = cdiv(i) > 1 && div[i] >= cdiv(i) / 2;
      logic l = c && en && px == 0;
      logic [2:0] d;
      d = (pdly(i) == 0) ? raw(n[i], en) : ((dl[i].size() == pdly(i)) ? dl[i][pdly(i)-1] : 3'b000);
      return {pc, CW'(px), CW'(py), d[1] ~^ hpol(i), ~d[0], d[2], 1'b0, l, l && py == 0, mfc[i]};
   endfunction

   task automatic cmp(input string nm, input int i, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s inst%0d at %0t: got %h, expected %h", nm, i, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         div[i] = 0;
         n[i] = 0;
         mfc[i] = '0;
         dl[i].delete();
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         if (!reset) begin
            logic t = div[i] == cdiv(i) - 1;
            div[i] = (div[i] + 1) % cdiv(i);
            if (!en) begin
               n[i] = 0;
               dl[i].delete();
            end else if (t) begin
               if (pdly(i) > 0) begin
                  dl[i].push_front(raw(n[i], 1'b1));
                  if (dl[i].size() > pdly(i)) void'(dl[i].pop_back());
               end
               if (n[i] == FT - 1) mfc[i] = mfc[i] + 16'd1;
               n[i] = (n[i] + 1) % FT;
            end
         end
      end
   endtask

   task automatic cyc(input logic n_en, input logic n_rst);
      @(posedge clk);
      #1;
      model_edge();
      en = n_en;
      reset = n_rst;
      if (n_rst) model_reset();
      for (int i = 0; i < 3; i++)
         if (!reset && div[i] == cdiv(i) - 1) sq[i].push_back(exp_vec(i));
   endtask

   task automatic rst_check();
      #1;
      for (int i = 0; i < 3; i++) begin
         cmp("rst_out", i, dv(i), rst_vec(i));
         cmp("rst_ce", i, OW'(ce[i]), '0);
      end
   endtask

   task automatic run_to(input int p);
      int k = 0;
      while (n[0] != p && k < 3000) begin
         cyc(1'b1, 1'b0);
         k++;
      end
      cmp("run_to", 0, OW'({xx[0], yy[0]}), OW'({CW'(p % HT), CW'(p / HT)}));
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (ce[i]) begin
            if (sq[i].size() == 0) cmp("extra_ce", i, OW'(ce[i]), '0);
            else cmp("sb", i, dv(i), sq[i].pop_front());
         end else begin
            cmp("idle_ev", i, OW'({ls[i], fs[i]}), '0);
         end
      end
      if (track && ce[0]) begin
         tk0++;
         if (ls[0]) ls_cnt++;
         if (fs[0]) begin
            if (last_fs >= 0) cmp("fs_gap", 0, OW'(tk0 - last_fs), OW'(FT));
            last_fs = tk0;
            fs_cnt++;
         end
      end
   end

   initial begin
      model_reset();
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      rst_check();
      track = 1'b1;
      cyc(1'b1, 1'b0);
      repeat (768) cyc(1'b1, 1'b0);
      track = 1'b0;
      cmp("fs_count", 0, OW'(fs_cnt), OW'(3));
      cmp("ls_count", 0, OW'(ls_cnt), OW'(24));
      cmp("fc_3", 0, OW'(fc[0]), OW'(3));
      run_to(2 * HT + 5);
      repeat (5) cyc(1'b0, 1'b0);
      cmp("en_low", 0, OW'({xx[0], yy[0], hs[0], vs[0], bb[0], ls[0], fs[0]}),
          OW'({CW'(0), CW'(0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      cmp("en_low_fc", 0, OW'(fc[0]), OW'(3));
      repeat (5) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      run_to(3 * HT + 9);
      cyc(1'b1, 1'b1);
      rst_check();
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      repeat (300) cyc(1'b1, 1'b0);
      for (int k = 0; k < 2500; k++) begin
         logic r = ($urandom % 400) == 0;
         cyc(($urandom % 40) != 0, r);
         if (r) begin
            rst_check();
            cyc(1'b1, 1'b1);
            cyc(1'b1, 1'b0);
         end
      end
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) cmp("drain", i, OW'(sq[i].size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
